// File: rtl/bps_mc_arb_pkg.sv
// Shared types and rdctl tag helpers for the bps memory-controller arbiter.
// The tag occupies the top cbits of rdctl and carries the issuing client id.
package bps_mc_pkg;

  localparam int MC_DATA_WIDTH = 64;
  localparam int RDCTL_WIDTH   = 32;
  localparam int ADDR_WIDTH    = 48;

  // One queued client request; stores carry data, loads carry rdctl in the low bits.
  typedef struct packed {
    logic                     is_ld;
    logic [ADDR_WIDTH-1:0]    vadr;
    logic [MC_DATA_WIDTH-1:0] wrd_rdctl;
  } req_entry_t;

  // Overwrite the top cbits of rdctl with the client id.
  function automatic logic [RDCTL_WIDTH-1:0] tag_insert(input logic [RDCTL_WIDTH-1:0] rdctl,
                                                        input logic [7:0] id, input int cbits);
    logic [RDCTL_WIDTH-1:0] keep;
    logic [RDCTL_WIDTH-1:0] tag;
    keep = {RDCTL_WIDTH{1'b1}} >> cbits;
    tag  = RDCTL_WIDTH'(id) << (RDCTL_WIDTH - cbits);
    return (rdctl & keep) | tag;
  endfunction

  // Zero the tag bits so the client sees its original rdctl.
  function automatic logic [RDCTL_WIDTH-1:0] tag_strip(input logic [RDCTL_WIDTH-1:0] rdctl,
                                                       input int cbits);
    return rdctl & ({RDCTL_WIDTH{1'b1}} >> cbits);
  endfunction

  // Recover the client id from a tagged rdctl.
  function automatic logic [7:0] tag_id(input logic [RDCTL_WIDTH-1:0] rdctl, input int cbits);
    return 8'(rdctl >> (RDCTL_WIDTH - cbits));
  endfunction

endpackage

// File: rtl/bps_mc_arb_if.sv
// MC-side port of the arbiter: request channel out, response channel in.
// master = arbiter, slave = memory controller.
interface bps_mc_arb_if #(
  parameter int ADDR_WIDTH  = bps_mc_pkg::ADDR_WIDTH,
  parameter int RDCTL_WIDTH = bps_mc_pkg::RDCTL_WIDTH
);
  logic                                 mc_req_ld;
  logic                                 mc_req_st;
  logic [ADDR_WIDTH-1:0]                mc_req_vadr;
  logic [bps_mc_pkg::MC_DATA_WIDTH-1:0] mc_req_wrd_rdctl;
  logic                                 mc_req_stall;
  logic [RDCTL_WIDTH-1:0]               mc_rsp_rdctl;
  logic [bps_mc_pkg::MC_DATA_WIDTH-1:0] mc_rsp_data;
  logic                                 mc_rsp_push;
  logic                                 mc_rsp_stall;

  modport master (
    output mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, mc_rsp_stall,
    input  mc_req_stall, mc_rsp_rdctl, mc_rsp_data, mc_rsp_push
  );

  modport slave (
    input  mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, mc_rsp_stall,
    output mc_req_stall, mc_rsp_rdctl, mc_rsp_data, mc_rsp_push
  );
endinterface

// File: rtl/bps_mc_arb_req_fifo.sv
// Per-client request FIFO with a registered almost-full stall.
// stall asserts once the next occupancy reaches DEPTH-1; the spare entry
// absorbs the request the client sends before it can see the stall.
module bps_mc_req_fifo
  import bps_mc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  req_entry_t din,
  input  logic       pop,
  output req_entry_t dout,
  output logic       empty,
  output logic       stall
);
  localparam int AW = $clog2(DEPTH);

  req_entry_t    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_nxt;
  logic          wr, rd;

  assign wr    = push & ~stall;
  assign empty = (cnt == '0);
  assign rd    = pop & ~empty;
  assign dout  = mem[rp];

  // Occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    cnt_nxt = cnt;
    if (wr && !rd)      cnt_nxt = cnt + 1'b1;
    else if (!wr && rd) cnt_nxt = cnt - 1'b1;
  end

  // Pointers, occupancy and registered stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      stall <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt   <= cnt_nxt;
      stall <= (cnt_nxt >= (AW+1)'(DEPTH-1));
    end
  end

  // Storage needs no reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
endmodule

// File: rtl/bps_mc_arb.sv
// bps_mc_arb: merges NUM_CLIENTS bps request streams onto one MC port with
// round-robin arbitration, tags load rdctl with the client id, and routes
// MC responses back by that tag.
// Optional: define BPS_MC_ARB_PERF_EN for 16-bit saturating perf counters
// dumped on debug/push_debug every 1024 cycles.
module bps_mc_arb
  import bps_mc_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int CLIENT_BITS = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = bps_mc_pkg::ADDR_WIDTH,
  parameter int RDCTL_WIDTH = bps_mc_pkg::RDCTL_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CLIENTS-1:0]             cl_req_ld,
  input  logic [NUM_CLIENTS-1:0]             cl_req_st,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]  cl_req_vadr,
  input  logic [NUM_CLIENTS*64-1:0]          cl_req_wrd_rdctl,
  output logic [NUM_CLIENTS-1:0]             cl_req_stall,
  output logic [NUM_CLIENTS*RDCTL_WIDTH-1:0] cl_rsp_rdctl,
  output logic [NUM_CLIENTS*64-1:0]          cl_rsp_data,
  output logic [NUM_CLIENTS-1:0]             cl_rsp_push,
  input  logic [NUM_CLIENTS-1:0]             cl_rsp_stall,
  bps_mc_arb_if.master                       mc
`ifdef BPS_MC_ARB_PERF_EN
  ,
  output logic                               push_debug,
  output logic [63:0]                        debug
`endif
);

  req_entry_t             din  [NUM_CLIENTS];
  req_entry_t             dout [NUM_CLIENTS];
  req_entry_t             head;
  logic [NUM_CLIENTS-1:0] empty;
  logic [NUM_CLIENTS-1:0] pop;
  logic [CLIENT_BITS-1:0] rr;
  logic [CLIENT_BITS-1:0] gnt_id;
  logic                   gnt_vld;
  logic [7:0]             rsp_id;

  // Per-client request queues; a simultaneous ld+st is kept as a load.
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cl
    assign din[i] = '{is_ld:     cl_req_ld[i],
                      vadr:      cl_req_vadr[i*ADDR_WIDTH +: ADDR_WIDTH],
                      wrd_rdctl: cl_req_wrd_rdctl[i*64 +: 64]};
    assign pop[i] = gnt_vld && (gnt_id == CLIENT_BITS'(i));

    bps_mc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cl_req_ld[i] | cl_req_st[i]),
      .din   (din[i]),
      .pop   (pop[i]),
      .dout  (dout[i]),
      .empty (empty[i]),
      .stall (cl_req_stall[i])
    );
  end

  // Round-robin pick: first non-empty client at or after rr. Iterating from the
  // far end down lets the nearest candidate win the last assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_CLIENTS-1; k >= 0; k--) begin
      if (!empty[(int'(rr) + k) % NUM_CLIENTS]) begin
        gnt_vld = 1'b1;
        gnt_id  = CLIENT_BITS'((int'(rr) + k) % NUM_CLIENTS);
      end
    end
    if (mc.mc_req_stall) gnt_vld = 1'b0;
  end

  assign head = dout[gnt_id];

  // MC request register: one-cycle ld/st pulse per grant; rr moves past the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr                  <= '0;
      mc.mc_req_ld        <= 1'b0;
      mc.mc_req_st        <= 1'b0;
      mc.mc_req_vadr      <= '0;
      mc.mc_req_wrd_rdctl <= '0;
    end else begin
      mc.mc_req_ld <= gnt_vld & head.is_ld;
      mc.mc_req_st <= gnt_vld & ~head.is_ld;
      if (gnt_vld) begin
        rr             <= (int'(gnt_id) == NUM_CLIENTS-1) ? '0 : gnt_id + 1'b1;
        mc.mc_req_vadr <= head.vadr;
        mc.mc_req_wrd_rdctl <= head.is_ld
          ? {{(MC_DATA_WIDTH-RDCTL_WIDTH){1'b0}},
             tag_insert(head.wrd_rdctl[RDCTL_WIDTH-1:0], 8'(gnt_id), CLIENT_BITS)}
          : head.wrd_rdctl;
      end
    end
  end

  // Responses are routed purely by tag, so no state is needed to return them.
  assign rsp_id          = tag_id(mc.mc_rsp_rdctl, CLIENT_BITS);
  assign mc.mc_rsp_stall = |cl_rsp_stall;

  // Response register: push only the tagged client; out-of-range ids match nobody.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cl_rsp_push  <= '0;
      cl_rsp_data  <= '0;
      cl_rsp_rdctl <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        cl_rsp_push[i] <= mc.mc_rsp_push && (rsp_id == 8'(i));
        if (mc.mc_rsp_push && (rsp_id == 8'(i))) begin
          cl_rsp_data[i*64 +: 64]                   <= mc.mc_rsp_data;
          cl_rsp_rdctl[i*RDCTL_WIDTH +: RDCTL_WIDTH] <= tag_strip(mc.mc_rsp_rdctl, CLIENT_BITS);
        end
      end
    end
  end

`ifdef BPS_MC_ARB_PERF_EN
  logic [9:0]  perf_cyc;
  logic [15:0] n_ld, n_st, n_stall, n_full;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Count events; at the end of each 1024-cycle window publish and clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cyc   <= '0;
      n_ld       <= '0;
      n_st       <= '0;
      n_stall    <= '0;
      n_full     <= '0;
      push_debug <= 1'b0;
      debug      <= '0;
    end else begin
      perf_cyc <= perf_cyc + 1'b1;
      if (perf_cyc == 10'd1023) begin
        debug      <= {sat_inc(n_ld, mc.mc_req_ld), sat_inc(n_st, mc.mc_req_st),
                       sat_inc(n_stall, mc.mc_req_stall), sat_inc(n_full, |cl_req_stall)};
        push_debug <= 1'b1;
        n_ld       <= '0;
        n_st       <= '0;
        n_stall    <= '0;
        n_full     <= '0;
      end else begin
        push_debug <= 1'b0;
        n_ld       <= sat_inc(n_ld, mc.mc_req_ld);
        n_st       <= sat_inc(n_st, mc.mc_req_st);
        n_stall    <= sat_inc(n_stall, mc.mc_req_stall);
        n_full     <= sat_inc(n_full, |cl_req_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bps_mc_arb.sv
// Directed + random bench for bps_mc_arb. The reference model keeps one
// queue per client and picks the next winner with a plain rotating search.
module tb_bps_mc_arb;
  localparam int N  = 2;
  localparam int CB = 1;
  localparam int D  = 4;
  localparam int AW = 48;
  localparam int RW = 32;
  localparam logic [31:0] MASK = 32'hFFFF_FFFF >> CB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    cl_req_ld, cl_req_st, cl_req_stall, cl_rsp_push, cl_rsp_stall;
  logic [N*AW-1:0] cl_req_vadr;
  logic [N*64-1:0] cl_req_wrd_rdctl, cl_rsp_data;
  logic [N*RW-1:0] cl_rsp_rdctl;

  bps_mc_arb_if #(.ADDR_WIDTH(AW), .RDCTL_WIDTH(RW)) mc ();

  bps_mc_arb #(.NUM_CLIENTS(N), .CLIENT_BITS(CB), .FIFO_DEPTH(D),
               .ADDR_WIDTH(AW), .RDCTL_WIDTH(RW)) dut (
    .clk              (clk),
    .rst              (rst),
    .cl_req_ld        (cl_req_ld),
    .cl_req_st        (cl_req_st),
    .cl_req_vadr      (cl_req_vadr),
    .cl_req_wrd_rdctl (cl_req_wrd_rdctl),
    .cl_req_stall     (cl_req_stall),
    .cl_rsp_rdctl     (cl_rsp_rdctl),
    .cl_rsp_data      (cl_rsp_data),
    .cl_rsp_push      (cl_rsp_push),
    .cl_rsp_stall     (cl_rsp_stall),
    .mc               (mc)
  );

  typedef struct {
    bit          ld;
    logic [47:0] vadr;
    logic [63:0] wrd;
  } ent_t;

  // reference model state
  ent_t        q [N][$];
  int          rr;
  bit          exp_stall [N];
  bit          e_ld, e_st;
  logic [47:0] e_vadr;
  logic [63:0] e_wrd;
  bit          e_push [N];
  logic [63:0] e_data [N];
  logic [31:0] e_rdctl [N];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      q[c].delete();
      exp_stall[c] = 1'b0;
      e_push[c]    = 1'b0;
    end
    rr = 0; e_ld = 1'b0; e_st = 1'b0;
  endtask

  // One clock: predict from the current inputs, advance, compare.
  task automatic cycle();
    bit   acc [N];
    ent_t ne  [N];
    ent_t e;
    int   g, rid;
    bit   rpush;
    #1;
    chk("mc_rsp_stall", mc.mc_rsp_stall, |cl_rsp_stall);
    for (int c = 0; c < N; c++) begin
      acc[c] = (cl_req_ld[c] | cl_req_st[c]) && !exp_stall[c];
      ne[c]  = '{ld: cl_req_ld[c], vadr: cl_req_vadr[c*AW +: AW], wrd: cl_req_wrd_rdctl[c*64 +: 64]};
    end
    g = -1;
    if (!mc.mc_req_stall)
      for (int k = 0; k < N; k++)
        if (g < 0 && q[(rr + k) % N].size() > 0) g = (rr + k) % N;
    rpush = mc.mc_rsp_push;
    rid   = int'(mc.mc_rsp_rdctl >> (RW - CB));
    @(posedge clk); #1;
    e_ld = 1'b0; e_st = 1'b0;
    if (g >= 0) begin
      e = q[g].pop_front();
      e_ld = e.ld; e_st = !e.ld; e_vadr = e.vadr;
      e_wrd = e.ld ? {32'h0, (e.wrd[31:0] & MASK) | (32'(g) << (RW - CB))} : e.wrd;
      rr = (g + 1) % N;
    end
    for (int c = 0; c < N; c++) begin
      if (acc[c]) q[c].push_back(ne[c]);
      exp_stall[c] = q[c].size() >= D - 1;
      e_push[c] = rpush && rid == c;
      if (e_push[c]) begin
        e_data[c]  = mc.mc_rsp_data;
        e_rdctl[c] = mc.mc_rsp_rdctl & MASK;
      end
    end
    chk("mc_req_ld", mc.mc_req_ld, e_ld);
    chk("mc_req_st", mc.mc_req_st, e_st);
    if (e_ld || e_st) begin
      chk("mc_req_vadr", mc.mc_req_vadr, e_vadr);
      chk("mc_req_wrd", mc.mc_req_wrd_rdctl, e_wrd);
    end
    for (int c = 0; c < N; c++) begin
      chk("cl_req_stall", cl_req_stall[c], exp_stall[c]);
      chk("cl_rsp_push", cl_rsp_push[c], e_push[c]);
      if (e_push[c]) begin
        chk("cl_rsp_data", cl_rsp_data[c*64 +: 64], e_data[c]);
        chk("cl_rsp_rdctl", cl_rsp_rdctl[c*RW +: RW], e_rdctl[c]);
      end
    end
  endtask

  task automatic clear_inputs();
    cl_req_ld = '0; cl_req_st = '0; cl_req_vadr = '0; cl_req_wrd_rdctl = '0;
    cl_rsp_stall = '0; mc.mc_req_stall = 1'b0;
    mc.mc_rsp_push = 1'b0; mc.mc_rsp_rdctl = '0; mc.mc_rsp_data = '0;
  endtask

  initial begin
    int nacc, seq, cnt;
    int seq_rr [N];
    int order [$];

    clear_inputs();
    model_reset();
    rst = 1'b0;
    #12;
    chk("rst_mc_ld", mc.mc_req_ld, 1'b0);
    chk("rst_mc_wrd", mc.mc_req_wrd_rdctl, 64'h0);
    chk("rst_req_stall", cl_req_stall, 2'b00);
    chk("rst_rsp_push", cl_rsp_push, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;

    // client 0 load, untagged rdctl, response back to client 0
    cl_req_ld[0] = 1'b1; cl_req_vadr[0 +: AW] = 48'h40; cl_req_wrd_rdctl[0 +: 64] = 64'h5;
    cycle();
    cl_req_ld = '0;
    cycle();
    chk("t1_mc_ld", mc.mc_req_ld, 1'b1);
    chk("t1_mc_vadr", mc.mc_req_vadr, 48'h40);
    chk("t1_mc_wrd", mc.mc_req_wrd_rdctl, 64'h0000_0005);
    mc.mc_rsp_push = 1'b1; mc.mc_rsp_rdctl = 32'h5; mc.mc_rsp_data = 64'hDEAD;
    cycle();
    mc.mc_rsp_push = 1'b0;
    chk("t1_rsp_push", cl_rsp_push, 2'b01);
    chk("t1_rsp_rdctl", cl_rsp_rdctl[0 +: RW], 32'h5);
    chk("t1_rsp_data", cl_rsp_data[0 +: 64], 64'hDEAD);

    // client 1 load gets tag bit 31
    cl_req_ld[1] = 1'b1; cl_req_vadr[AW +: AW] = 48'h80; cl_req_wrd_rdctl[64 +: 64] = 64'h7;
    cycle();
    cl_req_ld = '0;
    cycle();
    chk("t2_mc_wrd", mc.mc_req_wrd_rdctl, 64'h8000_0007);
    mc.mc_rsp_push = 1'b1; mc.mc_rsp_rdctl = 32'h8000_0007; mc.mc_rsp_data = 64'hBEEF;
    cycle();
    mc.mc_rsp_push = 1'b0;
    chk("t2_rsp_push", cl_rsp_push, 2'b10);
    chk("t2_rsp_rdctl", cl_rsp_rdctl[RW +: RW], 32'h7);
    cycle();

    // queue 3 loads behind a stalled MC, then reset mid-burst
    mc.mc_req_stall = 1'b1; cl_req_ld[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cl_req_vadr[0 +: AW] = 48'h200 + 48'(i);
      cycle();
    end
    chk("rs_stall_before", cl_req_stall[0], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rs_mc_ld", mc.mc_req_ld, 1'b0);
    chk("rs_req_stall", cl_req_stall, 2'b00);
    chk("rs_rsp_push", cl_rsp_push, 2'b00);
    model_reset();
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (mc.mc_req_ld || mc.mc_req_st) cnt++;
    end
    chk("rs_no_issue", cnt, 0);

    // both clients stream stores; grants must alternate 0,1,0,1
    cl_req_st = 2'b11;
    seq_rr[0] = 0; seq_rr[1] = 0;
    for (int i = 0; i < 24; i++) begin
      bit a [N];
      for (int c = 0; c < N; c++) begin
        cl_req_vadr[c*AW +: AW] = {4'(c), 44'(seq_rr[c])};
        cl_req_wrd_rdctl[c*64 +: 64] = {$urandom, $urandom};
        a[c] = !exp_stall[c];
      end
      if (i == 16) cl_req_st = 2'b00;
      cycle();
      if (i < 16) for (int c = 0; c < N; c++) if (a[c]) seq_rr[c]++;
      if (mc.mc_req_st) order.push_back(int'(mc.mc_req_vadr[47:44]));
    end
    chk("rr_cnt_ge4", order.size() >= 4, 1'b1);
    if (order.size() >= 4)
      for (int i = 0; i < 4; i++) chk("rr_order", order[i], i % 2);

    // MC stall for 20 cycles while client 0 keeps issuing loads
    mc.mc_req_stall = 1'b1; cl_req_ld[0] = 1'b1;
    nacc = 0; seq = 0;
    for (int i = 0; i < 20; i++) begin
      bit a;
      cl_req_vadr[0 +: AW] = 48'h1000 + 48'(seq);
      cl_req_wrd_rdctl[0 +: 64] = 64'(seq);
      a = !exp_stall[0];
      cycle();
      if (a) begin nacc++; seq++; end
    end
    chk("st_accepted", nacc, 3);
    chk("st_stall_high", cl_req_stall[0], 1'b1);
    mc.mc_req_stall = 1'b0; cl_req_ld = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (mc.mc_req_ld) cnt++;
    end
    chk("st_drained", cnt, 3);

    // response stall is combinational; stalled push still forwarded
    cl_rsp_stall = 2'b10;
    #1 chk("rsp_stall_comb", mc.mc_rsp_stall, 1'b1);
    mc.mc_rsp_push = 1'b1; mc.mc_rsp_rdctl = 32'h8000_0033; mc.mc_rsp_data = 64'h1234_5678;
    cycle();
    mc.mc_rsp_push = 1'b0; cl_rsp_stall = '0;
    chk("rsp_stall_push", cl_rsp_push, 2'b10);
    chk("rsp_stall_rdctl", cl_rsp_rdctl[RW +: RW], 32'h33);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        cl_req_ld[c] = ($urandom_range(0, 3) == 0);
        cl_req_st[c] = ($urandom_range(0, 3) == 0);
        cl_req_vadr[c*AW +: AW] = {$urandom, $urandom};
        cl_req_wrd_rdctl[c*64 +: 64] = {$urandom, $urandom & MASK};
        cl_rsp_stall[c] = ($urandom_range(0, 7) == 0);
      end
      mc.mc_req_stall = ($urandom_range(0, 3) == 0);
      mc.mc_rsp_push  = $urandom_range(0, 1);
      mc.mc_rsp_rdctl = $urandom;
      mc.mc_rsp_data  = {$urandom, $urandom};
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 12; i++) cycle();
    for (int c = 0; c < N; c++) chk("final_empty", q[c].size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bps_mc_arb.md
Name: bps_mc_arb

Overview:
Memory-request arbiter directly downstream of the bps tile's memory-controller port. It merges the mc_req_* streams of NUM_CLIENTS bps instances onto one MC port and tags each load's rdctl with the client id. It routes each MC response back to the client that issued the load. Each client has a small input FIFO, so a bps sees the same stall/push protocol it would see on a private MC port.

Parameters:
NUM_CLIENTS, 2, number of bps clients (2..8)
CLIENT_BITS, 1, width of the client id; must be at least log2(NUM_CLIENTS)
FIFO_DEPTH, 4, per-client request FIFO entries (power of 2, at least 4)
ADDR_WIDTH, 48, virtual address width
RDCTL_WIDTH, 32, MC rdctl width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
cl_req_ld  in  NUM_CLIENTS  per-client load request
cl_req_st  in  NUM_CLIENTS  per-client store request
cl_req_vadr  in  NUM_CLIENTS*ADDR_WIDTH  per-client address, client i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
cl_req_wrd_rdctl  in  NUM_CLIENTS*64  store data, or load rdctl in bits [RDCTL_WIDTH-1:0]
cl_req_stall  out  NUM_CLIENTS  per-client request backpressure
cl_rsp_rdctl  out  NUM_CLIENTS*RDCTL_WIDTH  returned rdctl with the tag bits zeroed
cl_rsp_data  out  NUM_CLIENTS*64  load data
cl_rsp_push  out  NUM_CLIENTS  response valid
cl_rsp_stall  in  NUM_CLIENTS  client response backpressure
mc_req_ld  out  1  load to MC
mc_req_st  out  1  store to MC
mc_req_vadr  out  ADDR_WIDTH  MC address
mc_req_wrd_rdctl  out  64  store data, or tagged rdctl
mc_req_stall  in  1  MC backpressure
mc_rsp_rdctl  in  RDCTL_WIDTH  tagged rdctl returned by MC
mc_rsp_data  in  64  load data
mc_rsp_push  in  1  MC response valid
mc_rsp_stall  out  1  backpressure to MC

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0; FIFOs emptied; round-robin pointer set to 0.
  - Reset applied mid-operation drops queued requests.
  - Responses arriving after reset are still routed, because routing is stateless.
- Request accept:
  - client i entry is written when (cl_req_ld[i] | cl_req_st[i]) is high and cl_req_stall[i] is low.
  - Requests presented while stall is high are ignored; the client must hold them.
  - ld and st both high: stored as a load, the st is dropped.
- cl_req_stall[i] is registered; it equals (next-cycle occupancy >= FIFO_DEPTH-1). The one spare entry absorbs the request issued in the cycle before stall becomes visible, so the FIFO never overflows.
- Arbitration:
  - a grant happens in a cycle where mc_req_stall is low and at least one FIFO is non-empty.
  - Round-robin: search starts at the client after the last granted one.
  - The granted head is popped; an enqueue and a pop on the same client in the same cycle leave occupancy unchanged.
- MC request stage:
  - registered, 1-cycle latency from grant.
  - mc_req_ld/st pulse for exactly one cycle per grant, otherwise 0.
  - No grant while mc_req_stall is high; an already-registered request is still presented once (MC provides slack).
- Tagging:
  - loads: mc_req_wrd_rdctl[RDCTL_WIDTH-1 -: CLIENT_BITS] = client id, remaining rdctl bits passed through, bits 63:RDCTL_WIDTH = 0.
  - Stores: data passed unchanged.
  - Client rdctl top CLIENT_BITS bits must be 0.
- Response routing:
  - on mc_rsp_push, decode the id from the top rdctl bits; registered 1 cycle.
  - cl_rsp_push[id]=1, cl_rsp_data[id]=data, cl_rsp_rdctl[id]=rdctl with the tag bits zeroed.
  - Other clients' push = 0. An id >= NUM_CLIENTS is dropped.
- mc_rsp_stall = OR of cl_rsp_stall (combinational). Pushes that arrive while stalled are still forwarded.
- Ordering: per-client request order is preserved; there is no cross-client ordering.

Optional Feature:
BPS_MC_ARB_PERF_EN:
- Defined: adds outputs push_debug (1) and debug (64).
  - Adds 16-bit saturating counters for loads issued, stores issued, mc_req_stall cycles, and cycles with any FIFO full.
  - Every 1024 cycles, debug = {ld, st, stall, full} and push_debug pulses for 1 cycle, then the counters clear.
- Undefined: no counters and no debug ports.

Decomposition:
- Package bps_mc_pkg holds:
  - localparams MC_DATA_WIDTH=64, RDCTL_WIDTH=32, ADDR_WIDTH=48;
  - request-entry struct {is_ld, vadr, wrd_rdctl};
  - the tag-insert and tag-strip functions.
- One natural sub-module, bps_mc_req_fifo (FIFO_DEPTH entries, registered almost-full stall), instantiated per client.

Test Plan:
- Single client 0 issues ld at vadr 0x40 with rdctl 0x5 -> mc_req_ld next cycle with mc_req_wrd_rdctl=0x00000005. MC returns rdctl 0x5 with data 0xDEAD -> cl_rsp_push[0] one cycle later, rdctl 0x5.
- Client 1 issues ld with rdctl 0x7 -> MC sees 0x80000007. Response 0x80000007 -> cl_rsp_push[1] only, rdctl 0x7.
- Both clients issue back-to-back stores continuously -> grants alternate 0,1,0,1; each client's addresses appear in issue order; no loss.
- mc_req_stall held high for 20 cycles while client 0 keeps issuing -> cl_req_stall[0] rises after 3 accepted requests; 3 requests issued in order after release.
- Assert rst low mid-burst with 3 entries queued -> all outputs 0 immediately; no queued request issued after reset release.
- Set cl_rsp_stall[1]=1 -> mc_rsp_stall=1 in the same cycle; a response for client 1 pushed during the stall is still forwarded.
